// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, S-boxes, Rcon, GF(2^8) arithmetic and key-schedule helpers.
// Used by both the encryption and decryption cores.
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StInitAdd,
    StInvShiftRows,
    StInvSubBytes,
    StKeyAdd,
    StInvMixColumns,
    StDone
  } aes_state_e;

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] a, int unsigned n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_expand_fwd(logic [127:0] k, logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_expand_inv(logic [127:0] k, logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Byte n = row + 4*col lives at bits [127-8n -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[127 - 8 * n -: 8] = inv_sbox(s[127 - 8 * n -: 8]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// Combinational AES InvMixColumns over all four columns of a 128-bit state.
module aes_inv_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [31:0] inv_mix_col(logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_o[127 - 32 * c -: 32] = inv_mix_col(data_i[127 - 32 * c -: 32]);
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: forward-expands the key to K10, then walks back one
// primitive per clock, recovering each earlier round key with the inverse key schedule.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] keyin,
  output logic [127:0] dout,
  output logic         done,
  output logic         busy
);

  aes_state_e   st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [127:0] key_fwd;
  logic [127:0] key_prev;
  logic [127:0] imc_out;

  assign key_fwd  = key_expand_fwd(key_q, rcon(round_q));
  assign key_prev = key_expand_inv(key_q, rcon(round_q + 4'd1));

  aes_inv_mixcolumns u_inv_mixcolumns (
    .data_i (data_q),
    .data_o (imc_out)
  );

  always_comb begin
    st_d    = st_q;
    ct_d    = ct_q;
    key_d   = key_q;
    data_d  = data_q;
    round_d = round_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (st_q)
      StIdle, StDone: begin
        if (start) begin
          ct_d    = din;
          key_d   = keyin;
          round_d = 4'd1;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          st_d    = StKeyExp;
        end
      end
      StKeyExp: begin
        key_d = key_fwd;
        if (round_q == 4'd10) begin
          round_d = 4'd9;
          st_d    = StInitAdd;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StInitAdd: begin
        data_d = ct_q ^ key_q;
        st_d   = StInvShiftRows;
      end
      StInvShiftRows: begin
        data_d = inv_shift_rows(data_q);
        st_d   = StInvSubBytes;
      end
      StInvSubBytes: begin
        data_d = inv_sub_bytes(data_q);
        st_d   = StKeyAdd;
      end
      StKeyAdd: begin
        key_d  = key_prev;
        data_d = data_q ^ key_prev;
        if (round_q == 4'd0) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          st_d   = StDone;
        end else begin
          st_d = StInvMixColumns;
        end
      end
      StInvMixColumns: begin
        data_d  = imc_out;
        round_d = round_q - 4'd1;
        st_d    = StInvShiftRows;
      end
      default: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        st_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      ct_q    <= '0;
      key_q   <= '0;
      data_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      data_q  <= data_d;
      round_q <= round_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = data_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
